// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with 2-entry queue and redirect
// Optional halt at end of program enabled by macro FETCH_HALT_EN.
module fetch_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int PROG_LENGTH = 16
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   output logic [DATA_WIDTH-1:0] PC,
   input  logic [DATA_WIDTH-1:0] Instruction,
   output logic [DATA_WIDTH-1:0] InstrOut,
   output logic [DATA_WIDTH-1:0] InstrPC,
   output logic                  InstrValid,
   input  logic                  InstrReady,
   input  logic [1:0]            RedirType,
   input  logic [25:0]           RedirImm,
   input  logic [DATA_WIDTH-1:0] RedirBase,
   output logic                  Done
);

   typedef enum logic [1:0] {ST_FETCH, ST_DRAIN, ST_DONE} state_t;

   state_t                state;
   state_t                next_state;
   logic [DATA_WIDTH-1:0] head_pc;
   logic [DATA_WIDTH-1:0] head_instr;
   logic [DATA_WIDTH-1:0] tail_pc;
   logic [DATA_WIDTH-1:0] tail_instr;
   logic [1:0]            count;
   logic                  redir;
   logic                  pop;
   logic                  push;
   logic [DATA_WIDTH-1:0] redir_target;

   assign redir      = (RedirType == 2'b01) || (RedirType == 2'b10);
   assign InstrValid = (count != 2'd0);
   assign pop        = InstrValid && InstrReady;
   // A full queue can still accept when its head leaves on the same edge.
   assign push       = (state == ST_FETCH) && ((count != 2'd2) || pop);
   assign InstrOut   = head_instr;
   assign InstrPC    = head_pc;

   always_comb begin
      redir_target = RedirBase + {{(DATA_WIDTH-1){1'b0}}, 1'b1}
                   + {{(DATA_WIDTH-16){RedirImm[15]}}, RedirImm[15:0]};
      if (RedirType == 2'b01)
         redir_target = {{(DATA_WIDTH-26){1'b0}}, RedirImm};
   end

`ifdef FETCH_HALT_EN
   localparam logic [DATA_WIDTH-1:0] LAST_PC = DATA_WIDTH'(PROG_LENGTH - 1);
   assign Done = (state == ST_DONE);
`else
   assign Done = 1'b0;
`endif

   always_comb begin
      next_state = state;
      if (redir)
         next_state = ST_FETCH;
`ifdef FETCH_HALT_EN
      else if (state == ST_FETCH && push && PC == LAST_PC)
         next_state = ST_DRAIN;
      else if (state == ST_DRAIN && pop && count == 2'd1)
         next_state = ST_DONE;
`endif
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state <= ST_FETCH;
      else
         state <= next_state;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         PC         <= '0;
         count      <= 2'd0;
         head_pc    <= '0;
         head_instr <= '0;
         tail_pc    <= '0;
         tail_instr <= '0;
      end else if (redir) begin
         PC    <= redir_target;
         count <= 2'd0;
      end else begin
         if (push)
            PC <= PC + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_pc    <= PC;
                  head_instr <= Instruction;
                  count      <= 2'd1;
               end else begin
                  tail_pc    <= PC;
                  tail_instr <= Instruction;
                  count      <= 2'd2;
               end
            end
            2'b01: begin
               head_pc    <= tail_pc;
               head_instr <= tail_instr;
               count      <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_pc    <= PC;
                  head_instr <= Instruction;
               end else begin
                  head_pc    <= tail_pc;
                  head_instr <= tail_instr;
                  tail_pc    <= PC;
                  tail_instr <= Instruction;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven bench with consume-order scoreboard for fetch_ctrl
// Expectations follow FETCH_HALT_EN when defined.
module tb_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic [31:0] InstrOut;
   logic [31:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;
   logic [1:0]  RedirType;
   logic [25:0] RedirImm;
   logic [31:0] RedirBase;
   logic        Done;

   fetch_ctrl #(.DATA_WIDTH(32), .PROG_LENGTH(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .PC(PC), .Instruction(Instruction),
      .InstrOut(InstrOut), .InstrPC(InstrPC), .InstrValid(InstrValid),
      .InstrReady(InstrReady), .RedirType(RedirType), .RedirImm(RedirImm),
      .RedirBase(RedirBase), .Done(Done)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a < 32'd16) ? (32'hC0DE_0000 | a) : 32'd0;
   endfunction

   assign Instruction = mem(PC);

   typedef struct {
      logic        ready;
      logic [1:0]  rtype;
      logic [25:0] imm;
      logic [31:0] base;
      int          pop_pc;
      logic        v;
      logic [31:0] ipc;
      logic [31:0] pc;
      logic        done;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb[$];
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic add(input logic r, input logic [1:0] t, input logic [25:0] im,
                      input logic [31:0] b, input int pp, input logic v,
                      input logic [31:0] ipc, input logic [31:0] pc, input logic d);
      vec_t x;
      x.ready = r; x.rtype = t; x.imm = im; x.base = b; x.pop_pc = pp;
      x.v = v; x.ipc = ipc; x.pc = pc; x.done = d;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] e;
      Reset_n = 1'b0; InstrReady = 1'b0; RedirType = 2'b00; RedirImm = '0; RedirBase = '0;

      add(0, 0, 0, 0, -1, 1, 0, 1, 0);
      add(0, 0, 0, 0, -1, 1, 0, 2, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, -1, 1, 0, 2, 0);
      add(1, 0, 0, 0, 0, 1, 1, 3, 0);
      add(1, 0, 0, 0, 1, 1, 2, 4, 0);
      add(1, 0, 0, 0, 2, 1, 3, 5, 0);
      add(1, 2, 26'h000FFFD, 11, -1, 0, 0, 9, 0);
      add(1, 0, 0, 0, -1, 1, 9, 10, 0);
      add(0, 0, 0, 0, -1, 1, 9, 11, 0);
      add(0, 0, 0, 0, -1, 1, 9, 11, 0);
      add(0, 1, 15, 0, -1, 0, 0, 15, 0);
      add(1, 0, 0, 0, -1, 1, 15, 16, 0);
`ifdef FETCH_HALT_EN
      add(1, 0, 0, 0, 15, 0, 0, 16, 1);
      add(1, 0, 0, 0, -1, 0, 0, 16, 1);
`else
      add(1, 0, 0, 0, 15, 1, 16, 17, 0);
      add(1, 0, 0, 0, 16, 1, 17, 18, 0);
`endif
      add(1, 1, 3, 0, -1, 0, 0, 3, 0);
      add(1, 0, 0, 0, -1, 1, 3, 4, 0);

      @(negedge Clk);
      @(negedge Clk);
      chk("reset PC", PC, 0);
      chk("reset valid", {31'd0, InstrValid}, 0);
      chk("reset InstrOut", InstrOut, 0);
      chk("reset InstrPC", InstrPC, 0);
      chk("reset Done", {31'd0, Done}, 0);
      Reset_n = 1'b1;

      foreach (vecs[k]) begin
         InstrReady = vecs[k].ready;
         RedirType  = vecs[k].rtype;
         RedirImm   = vecs[k].imm;
         RedirBase  = vecs[k].base;
         if (vecs[k].pop_pc >= 0) sb.push_back(32'(vecs[k].pop_pc));
         #1;
         if (InstrValid && InstrReady && RedirType != 2'b01 && RedirType != 2'b10) begin
            if (sb.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL row%0d unexpected consume: got pc %0h expected none", k, InstrPC);
            end else begin
               e = sb.pop_front();
               chk($sformatf("row%0d consumed pc", k), InstrPC, e);
               chk($sformatf("row%0d consumed instr", k), InstrOut, mem(e));
            end
         end
         @(negedge Clk);
         chk($sformatf("row%0d valid", k), {31'd0, InstrValid}, {31'd0, vecs[k].v});
         chk($sformatf("row%0d PC", k), PC, vecs[k].pc);
         chk($sformatf("row%0d Done", k), {31'd0, Done}, {31'd0, vecs[k].done});
         if (vecs[k].v) begin
            chk($sformatf("row%0d InstrPC", k), InstrPC, vecs[k].ipc);
            chk($sformatf("row%0d InstrOut", k), InstrOut, mem(vecs[k].ipc));
         end
      end
      chk("scoreboard leftover", 32'(sb.size()), 0);

      InstrReady = 1'b0; RedirType = 2'b00;
      @(negedge Clk);
      @(negedge Clk);
      RedirType = 2'b01; RedirImm = 26'd7;
      #2 Reset_n = 1'b0;
      #1;
      chk("async PC", PC, 0);
      chk("async valid", {31'd0, InstrValid}, 0);
      chk("async InstrOut", InstrOut, 0);
      chk("async InstrPC", InstrPC, 0);
      chk("async Done", {31'd0, Done}, 0);
      @(negedge Clk);
      RedirType = 2'b00; InstrReady = 1'b1; Reset_n = 1'b1;
      @(negedge Clk);
      chk("restart valid", {31'd0, InstrValid}, 1);
      chk("restart InstrPC", InstrPC, 0);
      chk("restart InstrOut", InstrOut, mem(0));
      chk("restart PC", PC, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
